// File: rtl/mux_3way.sv
// mux_3way: two- or three-input data multiplexer with a registered copy of the
// selected data and an optional sticky illegal-select flag.
//
// Parameters
//   SIZE   : data width in bits (1..64)
//   IS3WAY : 1 = three-input mux (2-bit sel), 0 = two-input mux (1-bit sel)
//
// Ports
//   clk     : clock; all registers update on the rising edge
//   rst_n   : synchronous active-low reset
//   sel     : input select (2 bits when IS3WAY=1, 1 bit when IS3WAY=0)
//   in1     : data input 1
//   in2     : data input 2
//   in3     : data input 3 (ignored when IS3WAY=0)
//   out     : combinationally selected data
//   out_q   : out registered by one clock
//   sel_err : sticky flag, set by sel=2'b11 in three-input mode
//
// Optional feature
//   MUX_SEL_CHECK_EN : when defined, sel_err records sel=2'b11 seen on any
//                      rising edge outside reset; otherwise sel_err is tied 0.
module mux_3way #(
  parameter int SIZE   = 16,
  parameter int IS3WAY = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [((IS3WAY != 0) ? 2 : 1)-1:0] sel,
  input  logic [SIZE-1:0]                   in1,
  input  logic [SIZE-1:0]                   in2,
  input  logic [SIZE-1:0]                   in3,
  output logic [SIZE-1:0]                   out,
  output logic [SIZE-1:0]                   out_q,
  output logic                              sel_err
);

  logic [SIZE-1:0] w_out;
  logic [SIZE-1:0] r_out_q;

  generate
    if (IS3WAY != 0) begin : g_three_way
      // Encoding is in1/in3/in2 for 00/01/10; the unused code 11 falls back to in1.
      always_comb begin
        w_out = in1;
        case (sel)
          2'b01:   w_out = in3;
          2'b10:   w_out = in2;
          default: w_out = in1;
        endcase
      end
    end else begin : g_two_way
      // in3 stays on the port list for drop-in compatibility but has no effect.
      logic w_unused_in3;
      assign w_unused_in3 = ^in3;

      always_comb begin
        w_out = sel[0] ? in2 : in1;
      end
    end
  endgenerate

  assign out = w_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign out_q = r_out_q;

`ifdef MUX_SEL_CHECK_EN
  logic w_sel_ill;
  logic r_sel_err;

  // Only the three-input mode has an illegal code; two-input mode never flags.
  always_comb begin
    w_sel_ill = (IS3WAY != 0) && (sel == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_sel_ill) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_3way.sv
// Scoreboard bench for mux_3way: three instances (3-way/16b, 2-way/16b,
// 2-way/2b) share data inputs; each stimulus step queues hand-computed
// expectations tagged with the cycle they apply to, and a monitor on the
// falling edge pops and compares them.
module tb_mux_3way;

  localparam int D_A = 0; // IS3WAY=1, SIZE=16
  localparam int D_B = 1; // IS3WAY=0, SIZE=16
  localparam int D_C = 2; // IS3WAY=0, SIZE=2

  localparam int K_OUT = 0;
  localparam int K_OUTQ = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    logic [63:0] v;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        sel_c;
  logic [15:0] in1, in2, in3;

  logic [15:0] out_a, outq_a, out_b, outq_b;
  logic [1:0]  out_c, outq_c;
  logic        err_a, err_b, err_c;

  int   cyc;
  int   n_chk;
  int   n_fail;
  int   step_no;
  exp_t sb[$];

  mux_3way #(.SIZE(16), .IS3WAY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .sel(sel_a),
    .in1(in1), .in2(in2), .in3(in3),
    .out(out_a), .out_q(outq_a), .sel_err(err_a)
  );

  mux_3way #(.SIZE(16), .IS3WAY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .sel(sel_b),
    .in1(in1), .in2(in2), .in3(in3),
    .out(out_b), .out_q(outq_b), .sel_err(err_b)
  );

  mux_3way #(.SIZE(2), .IS3WAY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .sel(sel_c),
    .in1(in1[1:0]), .in2(in2[1:0]), .in3(in3[1:0]),
    .out(out_c), .out_q(outq_c), .sel_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, step=%0d required=done", step_no);
    $fatal(1);
  end

  function automatic logic [63:0] actual(int d, int k);
    logic [63:0] r;
    r = '0;
    case (d)
      D_A: r = (k == K_OUT) ? {48'd0, out_a} : (k == K_OUTQ) ? {48'd0, outq_a} : {63'd0, err_a};
      D_B: r = (k == K_OUT) ? {48'd0, out_b} : (k == K_OUTQ) ? {48'd0, outq_b} : {63'd0, err_b};
      default: r = (k == K_OUT) ? {62'd0, out_c} : (k == K_OUTQ) ? {62'd0, outq_c} : {63'd0, err_c};
    endcase
    return r;
  endfunction

  function automatic void push(int c, int d, int k, logic [63:0] v, string nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.kind = k; e.v = v; e.nm = nm;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation that has come due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [63:0] a;
      e = sb.pop_front();
      a = actual(e.dut, e.kind);
      n_chk++;
      if (e.cyc != cyc || a !== e.v) begin
        n_fail++;
        $display("FAIL %s: cycle=%0d actual=%0h required=%0h (due cycle %0d)",
                 e.nm, cyc, a, e.v, e.cyc);
      end
    end
  end

  // One stimulus step: apply inputs just after a rising edge, queue this
  // cycle's combinational outputs and the register values after the next edge.
  task automatic step(input logic r, input logic [1:0] sa, input logic sb_sel,
                      input logic sc, input logic [15:0] a1, input logic [15:0] a2,
                      input logic [15:0] a3, input logic [15:0] ea, input logic [15:0] eb,
                      input logic [1:0] ec, input logic err_if_en);
    logic err_exp;
`ifdef MUX_SEL_CHECK_EN
    err_exp = err_if_en;
`else
    err_exp = 1'b0;
`endif
    @(posedge clk);
    #1;
    step_no++;
    rst_n = r; sel_a = sa; sel_b = sb_sel; sel_c = sc;
    in1 = a1; in2 = a2; in3 = a3;
    push(cyc,     D_A, K_OUT,  {48'd0, ea}, $sformatf("a_out_s%0d", step_no));
    push(cyc,     D_B, K_OUT,  {48'd0, eb}, $sformatf("b_out_s%0d", step_no));
    push(cyc,     D_C, K_OUT,  {62'd0, ec}, $sformatf("c_out_s%0d", step_no));
    push(cyc + 1, D_A, K_OUTQ, r ? {48'd0, ea} : 64'd0, $sformatf("a_outq_s%0d", step_no));
    push(cyc + 1, D_B, K_OUTQ, r ? {48'd0, eb} : 64'd0, $sformatf("b_outq_s%0d", step_no));
    push(cyc + 1, D_C, K_OUTQ, r ? {62'd0, ec} : 64'd0, $sformatf("c_outq_s%0d", step_no));
    push(cyc + 1, D_A, K_ERR,  {63'd0, err_exp}, $sformatf("a_err_s%0d", step_no));
    push(cyc + 1, D_B, K_ERR,  64'd0, $sformatf("b_err_s%0d", step_no));
    push(cyc + 1, D_C, K_ERR,  64'd0, $sformatf("c_err_s%0d", step_no));
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; step_no = 0;
    rst_n = 1'b0; sel_a = 2'b00; sel_b = 1'b0; sel_c = 1'b0;
    in1 = 16'h000F; in2 = 16'h00F1; in3 = 16'h0F02;
    repeat (2) @(posedge clk);

    //    rst  sel_a  b     c     in1       in2       in3       exp_a     exp_b     exp_c  err
    step(1'b0, 2'b00, 1'b0, 1'b0, 16'h000F, 16'h00F1, 16'h0F02, 16'h000F, 16'h000F, 2'b11, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 16'h000F, 16'h00F1, 16'h0F02, 16'h000F, 16'h000F, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b1, 16'h000F, 16'h00F1, 16'h0F02, 16'h00F1, 16'h00F1, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0, 16'h000F, 16'h00F1, 16'h0F02, 16'h0F02, 16'h00F1, 2'b11, 1'b0);
    // in3 changes: only the three-way instance may react
    step(1'b1, 2'b01, 1'b0, 1'b1, 16'h000F, 16'h00F1, 16'hFFFF, 16'hFFFF, 16'h000F, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b1, 16'h000F, 16'h00F1, 16'h1234, 16'h1234, 16'h000F, 2'b01, 1'b0);
    // illegal select falls back to in1 and sets the sticky flag
    step(1'b1, 2'b11, 1'b1, 1'b0, 16'h000F, 16'h00F1, 16'h0F02, 16'h000F, 16'h00F1, 2'b11, 1'b1);
    step(1'b1, 2'b00, 1'b1, 1'b0, 16'h000F, 16'h00F1, 16'h0F02, 16'h000F, 16'h00F1, 2'b11, 1'b1);
    step(1'b1, 2'b10, 1'b0, 1'b1, 16'h000F, 16'h00F1, 16'h0F02, 16'h00F1, 16'h000F, 2'b01, 1'b1);
    // mid-run reset: out keeps the selected input, registers clear
    step(1'b0, 2'b10, 1'b0, 1'b1, 16'h000F, 16'h00F1, 16'h0F02, 16'h00F1, 16'h000F, 2'b01, 1'b0);
    // reset wins over an illegal select on the same edge
    step(1'b0, 2'b11, 1'b1, 1'b0, 16'h000F, 16'h00F1, 16'h0F02, 16'h000F, 16'h00F1, 2'b11, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 16'h000F, 16'h00F1, 16'h0F02, 16'h000F, 16'h000F, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b1, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'h5A5A, 16'hA5A5, 2'b10, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'h3C3C, 16'h5A5A, 2'b01, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: actual=%0d pending required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
